// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and position types for the 640x480@60 Hz
// raster generator (vga_timing and its wrap_counter instances).
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned HPOS_W  = 10;
  localparam int unsigned VCNT_W  = 10;
  localparam int unsigned VPOS_W  = 9;
  localparam int unsigned FRAME_W = 32;

  typedef logic [HPOS_W-1:0]  hpos_t;
  typedef logic [VPOS_W-1:0]  vpos_t;
  typedef logic [VCNT_W-1:0]  vcnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Half-open window test [lo, hi) on a 10-bit counter value
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage : vga_pkg

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MODULUS up-counter with an increment enable.
// Ports:
//   clk, rst_n : clock, async active-low reset (count resets to 0)
//   inc        : advance by one this cycle
//   count      : current registered value
//   next       : value the counter takes after the coming edge
//   wrap       : high when this edge takes count from MODULUS-1 back to 0
module wrap_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;

  // Wrap only fires on an incrementing cycle, so cascaded instances chain cleanly
  assign wrap = inc && (r_cnt == LAST);

  // Next-value decode, shared by the register and the look-ahead output
  always_comb begin
    next = r_cnt;
    if (wrap) begin
      next = '0;
    end else if (inc) begin
      next = r_cnt + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= next;
    end
  end

  assign count = r_cnt;

endmodule : wrap_counter

// File: rtl/vga_timing.sv
// vga_timing: free-running 640x480@60 Hz raster timing generator.
// Two chained wrap counters (column 0..799, line 0..524) plus a frame counter.
// Ports:
//   clk, rst_n        : pixel clock, async active-low reset
//   position_x/_NEXT  : current column / column after the next edge
//   position_y/_NEXT  : current line / line after the next edge (low 9 bits)
//   frame             : completed-frame count, wraps modulo 2^32
//   hsync, vsync      : active-low sync strobes
//   visible           : current pixel is inside the active area
// Build option VGA_SYNC_DELAY_EN: adds one register stage to hsync/vsync/visible
// so they line up with a downstream registered RGB stage.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  position_x,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame,
  output logic        hsync,
  output logic        vsync,
  output logic        visible
);

  localparam hpos_t H_VIS_END = hpos_t'(H_VISIBLE);
  localparam hpos_t HS_START  = hpos_t'(H_VISIBLE + H_FRONT);
  localparam hpos_t HS_END    = hpos_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam vcnt_t V_VIS_END = vcnt_t'(V_VISIBLE);
  localparam vcnt_t VS_START  = vcnt_t'(V_VISIBLE + V_FRONT);
  localparam vcnt_t VS_END    = vcnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  hpos_t  w_h_cnt;
  hpos_t  w_h_next;
  logic   w_h_wrap;
  vcnt_t  w_v_cnt;
  vcnt_t  w_v_next;
  logic   w_v_wrap;
  logic   w_unused_vcnt_msb;

  logic   w_hsync_nxt;
  logic   w_vsync_nxt;
  logic   w_visible_nxt;

  frame_t r_frame;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_visible;

  // Column counter, always counting
  wrap_counter #(
    .MODULUS (H_TOTAL),
    .WIDTH   (HPOS_W)
  ) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .count (w_h_cnt),
    .next  (w_h_next),
    .wrap  (w_h_wrap)
  );

  // Line counter, advanced by the end-of-line wrap
  wrap_counter #(
    .MODULUS (V_TOTAL),
    .WIDTH   (VCNT_W)
  ) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_h_wrap),
    .count (w_v_cnt),
    .next  (w_v_next),
    .wrap  (w_v_wrap)
  );

  // Lines 512..524 alias onto 0..12 in the 9-bit outputs; consumers gate with visible
  assign w_unused_vcnt_msb = w_v_cnt[9];

  // Frame counter; v wrap can only fire together with the h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (w_v_wrap) begin
      r_frame <= r_frame + FRAME_W'(1);
    end
  end

  // Strobe decode from the look-ahead counters so the registered strobes
  // line up with the positions they describe
  always_comb begin
    w_hsync_nxt   = !in_window(w_h_next, HS_START, HS_END);
    w_vsync_nxt   = !in_window(w_v_next, VS_START, VS_END);
    w_visible_nxt = (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);
  end

  // Strobe registers; reset values match the decode of position (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_visible <= 1'b1;
    end else begin
      r_hsync   <= w_hsync_nxt;
      r_vsync   <= w_vsync_nxt;
      r_visible <= w_visible_nxt;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_d;
  logic r_vsync_d;
  logic r_visible_d;

  // Extra stage to match the downstream registered colour path at the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_d   <= 1'b1;
      r_vsync_d   <= 1'b1;
      r_visible_d <= 1'b0;
    end else begin
      r_hsync_d   <= r_hsync;
      r_vsync_d   <= r_vsync;
      r_visible_d <= r_visible;
    end
  end

  assign hsync   = r_hsync_d;
  assign vsync   = r_vsync_d;
  assign visible = r_visible_d;
`else
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign visible = r_visible;
`endif

  assign position_x      = w_h_cnt;
  assign position_x_NEXT = w_h_next;
  assign position_y      = w_v_cnt[8:0];
  assign position_y_NEXT = w_v_next[8:0];
  assign frame           = r_frame;

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed, table-driven bench for vga_timing, with hand-written
// sequences for line/frame wraps, sync windows, frame rollover and async reset.
module tb_vga_timing;

  logic        clk;
  logic        rst_n;
  logic [9:0]  position_x;
  logic [9:0]  position_x_NEXT;
  logic [8:0]  position_y;
  logic [8:0]  position_y_NEXT;
  logic [31:0] frame;
  logic        hsync;
  logic        vsync;
  logic        visible;

  int checks = 0;
  int errors = 0;

  logic [9:0] jump_x;
  logic [9:0] jump_y;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DELAYED = 1'b1;
`else
  localparam bit DELAYED = 1'b0;
`endif

  vga_timing dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .position_x      (position_x),
    .position_x_NEXT (position_x_NEXT),
    .position_y      (position_y),
    .position_y_NEXT (position_y_NEXT),
    .frame           (frame),
    .hsync           (hsync),
    .vsync           (vsync),
    .visible         (visible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   adv;
    int   x;
    int   y;
    int   xn;
    int   yn;
    logic hs;
    logic vs;
    logic vis;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Teleport the counters while clk is low; the next edge counts on from there
  task jump(input int x, input int y);
    jump_x = 10'(x);
    jump_y = 10'(y);
    force dut.u_h_cnt.r_cnt = jump_x;
    force dut.u_v_cnt.r_cnt = jump_y;
    #1;
    release dut.u_h_cnt.r_cnt;
    release dut.u_v_cnt.r_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int hs_low;
    int hs_first;
    int vis_first;
    int vs_low;
    int vs_viol;
    int vis_cnt;

    // adv, x, y, x_NEXT, y_NEXT, hsync, vsync, visible (aligned build)
    tbl[0] = '{0,   0,   0, 1,   0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1,   1,   0, 2,   0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{638, 639, 0, 640, 0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1,   640, 0, 641, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{15,  655, 0, 656, 0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1,   656, 0, 657, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{95,  751, 0, 752, 0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1,   752, 0, 753, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{47,  799, 0, 0,   1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1,   0,   1, 1,   1, 1'b1, 1'b1, 1'b1};

    // Reset state, sampled between edges while held in reset
    rst_n = 1'b0;
    #12;
    chk("rst_x",    32'(position_x),      32'd0);
    chk("rst_y",    32'(position_y),      32'd0);
    chk("rst_xn",   32'(position_x_NEXT), 32'd1);
    chk("rst_yn",   32'(position_y_NEXT), 32'd0);
    chk("rst_frame", frame,               32'd0);
    chk("rst_hsync", 32'(hsync),          32'd1);
    chk("rst_vsync", 32'(vsync),          32'd1);
    chk("rst_visible", 32'(visible),      DELAYED ? 32'd0 : 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    // First line, table-driven
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].adv);
      chk($sformatf("vec%0d_x", i),  32'(position_x),      32'(tbl[i].x));
      chk($sformatf("vec%0d_y", i),  32'(position_y),      32'(tbl[i].y));
      chk($sformatf("vec%0d_xn", i), 32'(position_x_NEXT), 32'(tbl[i].xn));
      chk($sformatf("vec%0d_yn", i), 32'(position_y_NEXT), 32'(tbl[i].yn));
      chk($sformatf("vec%0d_frame", i), frame, 32'd0);
      if (!DELAYED) begin
        chk($sformatf("vec%0d_hsync", i),   32'(hsync),   32'(tbl[i].hs));
        chk($sformatf("vec%0d_vsync", i),   32'(vsync),   32'(tbl[i].vs));
        chk($sformatf("vec%0d_visible", i), 32'(visible), 32'(tbl[i].vis));
      end
    end

    // Full line 1: hsync width and where hsync / visible first drop
    hs_low = 0;
    hs_first = -1;
    vis_first = -1;
    for (int c = 0; c < 800; c++) begin
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(position_x);
      end
      if (!visible && vis_first < 0) vis_first = int'(position_x);
      step(1);
    end
    chk("hs_low_count", 32'(hs_low),    32'd96);
    chk("hs_fall_x",    32'(hs_first),  DELAYED ? 32'd657 : 32'd656);
    chk("vis_fall_x",   32'(vis_first), DELAYED ? 32'd641 : 32'd640);
    chk("line2_x",      32'(position_x), 32'd0);
    chk("line2_y",      32'(position_y), 32'd2);

    // Lines 489..492: vsync low only on lines 490-491
    jump(798, 488);
    step(2);
    chk("vjump_y", 32'(position_y), 32'd489);
    vs_low = 0;
    vs_viol = 0;
    for (int c = 0; c < 3200; c++) begin
      if (!vsync) vs_low++;
      if (!DELAYED && ((!vsync) != (position_y == 9'd490 || position_y == 9'd491))) vs_viol++;
      step(1);
    end
    chk("vs_low_count", 32'(vs_low), 32'd1600);
    if (!DELAYED) chk("vs_window", 32'(vs_viol), 32'd0);

    // Lines 479..480: last active line then blanking
    jump(798, 478);
    step(2);
    vis_cnt = 0;
    for (int c = 0; c < 1600; c++) begin
      if (visible) vis_cnt++;
      step(1);
    end
    chk("vis_count_479_480", 32'(vis_cnt), 32'd640);

    // Frame boundary: (799,524) -> (0,0) bumps frame 0 -> 1
    jump(797, 524);
    step(2);
    chk("fend_x",   32'(position_x),      32'd799);
    chk("fend_xn",  32'(position_x_NEXT), 32'd0);
    chk("fend_yn",  32'(position_y_NEXT), 32'd0);
    chk("fend_frame", frame,              32'd0);
    step(1);
    chk("fwrap_x",  32'(position_x), 32'd0);
    chk("fwrap_y",  32'(position_y), 32'd0);
    chk("fwrap_frame", frame,        32'd1);
    if (!DELAYED) begin
      chk("fwrap_visible", 32'(visible), 32'd1);
      chk("fwrap_vsync",   32'(vsync),   32'd1);
    end

    // Frame counter rollover at 2^32
    force dut.r_frame = 32'hFFFF_FFFF;
    jump(797, 524);
    release dut.r_frame;
    step(2);
    chk("froll_pre", frame, 32'hFFFF_FFFF);
    step(1);
    chk("froll_frame", frame,        32'h0000_0000);
    chk("froll_x", 32'(position_x),  32'd0);
    chk("froll_y", 32'(position_y),  32'd0);

    // Async reset mid-line at (300,200), asserted between edges
    jump(298, 200);
    step(2);
    chk("pre_rst_x", 32'(position_x), 32'd300);
    chk("pre_rst_y", 32'(position_y), 32'd200);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x",     32'(position_x),      32'd0);
    chk("arst_y",     32'(position_y),      32'd0);
    chk("arst_xn",    32'(position_x_NEXT), 32'd1);
    chk("arst_frame", frame,                32'd0);
    chk("arst_hsync", 32'(hsync),           32'd1);
    chk("arst_vsync", 32'(vsync),           32'd1);
    chk("arst_visible", 32'(visible),       DELAYED ? 32'd0 : 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_x", 32'(position_x), 32'd0);
    step(1);
    chk("resume_x", 32'(position_x), 32'd1);
    chk("resume_y", 32'(position_y), 32'd0);
    chk("resume_frame", frame,       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640×480@60 Hz VGA output. Produces current and next-cycle pixel coordinates, a 32-bit frame counter, and the hsync/vsync/visible strobes. Sits directly upstream of the pattern/image stage, which registers RGB from the `_NEXT` coordinates. Drives the board VGA connector sync pins alongside that stage's colour outputs.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch

Ports:
- `clk`  in  1  pixel clock (25.175 MHz nominal), one pixel per cycle
- `rst_n`  in  1  asynchronous, active-low reset
- `position_x`  out  10  current column, 0..H_TOTAL-1
- `position_x_NEXT`  out  10  column on the next cycle
- `position_y`  out  9  current line, low 9 bits of the 10-bit line counter
- `position_y_NEXT`  out  9  line on the next cycle, low 9 bits
- `frame`  out  32  completed-frame count
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `visible`  out  1  high when the current pixel lies in the active area

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Internal registers: `h_cnt[9:0]`, `v_cnt[9:0]`, `frame[31:0]`.
- Each clk, `h_cnt` increments. At H_TOTAL-1 it wraps to 0, and `v_cnt` increments in the same edge.
- `v_cnt` wraps from V_TOTAL-1 to 0 only on the edge where `h_cnt` also wraps. That edge increments `frame`, with modulo 2^32 wrap.
- `position_x = h_cnt`. `position_y = v_cnt[8:0]`; lines 512..524 alias to 0..12, and consumers gate with `visible`.
- `_NEXT` outputs are combinational from the counters and equal exactly the values the counters take after the next edge, including both wraps.
- `hsync` is low iff H_VISIBLE+H_FRONT ≤ h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- `vsync` is low iff V_VISIBLE+V_FRONT ≤ v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- `visible` = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- All sync and visible decodes are registered from the `_NEXT` counter values, so they are glitch-free and aligned with `position_*`.
- There is no state machine beyond the two chained wrap counters. Runs freely and has no stall input.

## Timing
- Reset (async assert, deassert sampled at clk):
  - position_x = 0, position_y = 0, position_x_NEXT = 1, position_y_NEXT = 0
  - frame = 0, hsync = 1, vsync = 1, visible = 1
- The first edge after reset deassertion moves position_x to 1.
- Reset asserted mid-frame forces the reset values immediately, independent of clk, and restarts at (0,0) with frame = 0.
- Latency: `position_*`, `hsync`, `vsync` and `visible` are mutually aligned with 0 cycles skew (no VGA_SYNC_DELAY_EN).
- Line period is 800 clocks and frame period is 420 000 clocks.
- Simultaneous events: at (799,524), one edge performs the h wrap, v wrap and frame increment together.

## Configuration
- `VGA_SYNC_DELAY_EN` defined: `hsync`, `vsync` and `visible` pass through one extra register stage.
  - They then lag `position_*` by 1 cycle, matching the downstream stage's registered RGB at the pins.
  - Delay registers reset to hsync = 1, vsync = 1, visible = 0.
- Not defined: strobes are aligned with `position_*` as above.
- Counters, positions and frame are identical in both builds.

## Structure
- Package `vga_pkg`:
  - default timing localparams (H_*/V_* values, H_TOTAL, V_TOTAL)
  - `typedef logic [9:0] hpos_t`
  - `typedef logic [8:0] vpos_t`
- Sub-module `wrap_counter`: parameterised modulus, with `inc` in and `wrap` out.
  - Instantiated twice. The horizontal instance's `wrap` drives the vertical instance's `inc`.
  - Exposes its own `next` value to build the `_NEXT` outputs.

## Test plan
- Reset then release: first sample gives x = 0, y = 0, x_NEXT = 1, visible = 1, hsync = vsync = 1, frame = 0. After 1 edge, x = 1.
- Run 800 clocks from (0,0):
  - at x = 799, x_NEXT = 0 and y_NEXT = 1
  - next edge gives x = 0, y = 1
  - hsync is low for exactly 96 clocks starting at x = 656
- Run one full frame (420 000 clocks):
  - vsync is low during lines 490–491 only
  - visible is high for 307 200 clocks
  - frame becomes 1 on the edge from (799,524) to (0,0)
- Preload frame = 0xFFFFFFFF via force and cross a frame boundary: frame = 0x00000000 and positions = (0,0) on the same edge.
- Assert rst_n low mid-line at (300,200) between clock edges: outputs take reset values immediately, before the next clk edge. After release, the count resumes from (0,0).
- With VGA_SYNC_DELAY_EN defined: hsync falls at x = 657 and visible falls at x = 641, each 1 cycle later than in the non-delayed build. Positions are unchanged.
